// File: rtl/gf180mcu_osu_sc_12t_clkgate_seq_if.sv
// Bus bundle for the staggered clock-enable sequencer: requests in, ICG enables/acks/busy out.
// TE exists only when GF180MCU_OSU_SC_CLKSEQ_TESTMODE_EN is defined.
interface gf180mcu_osu_sc_12t_clkgate_seq_if #(
  parameter int N = 4
);
  logic [N-1:0] REQ;
`ifdef GF180MCU_OSU_SC_CLKSEQ_TESTMODE_EN
  logic         TE;
`endif
  logic [N-1:0] EN;
  logic [N-1:0] ACK;
  logic         BUSY;

`ifdef GF180MCU_OSU_SC_CLKSEQ_TESTMODE_EN
  modport master (output REQ, output TE, input EN, input ACK, input BUSY);
  modport slave  (input REQ, input TE, output EN, output ACK, output BUSY);
`else
  modport master (output REQ, input EN, input ACK, input BUSY);
  modport slave  (input REQ, output EN, output ACK, output BUSY);
`endif
endinterface

// File: rtl/gf180mcu_osu_sc_12t_clkgate_seq.sv
// Staggered ICG enable sequencer: one enable change per slot, round-robin, STAGGER idle cycles after each change.
// Optional scan/test override of all enables: define GF180MCU_OSU_SC_CLKSEQ_TESTMODE_EN.
//
// state    | meaning
// ST_IDLE  | no change in flight; pick next mismatched branch from ptr
// ST_APPLY | re-sample REQ[idx] and commit EN[idx] on the exiting edge
// ST_WAIT  | di/dt spacing countdown after a real enable change
module gf180mcu_osu_sc_12t_clkgate_seq #(
  parameter int N       = 4,
  parameter int STAGGER = 4
) (
  input  logic CLK,
  input  logic R,
  gf180mcu_osu_sc_12t_clkgate_seq_if.slave bus
);
  localparam int PW = $clog2(N);
  localparam int CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  en_q, en_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;

  logic [N-1:0]  mis;
  logic          sel_vld;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] cand;
  logic [PW:0]   sum;

  assign mis = bus.REQ ^ en_q;

  // Scan from ptr upward with wrap; the first mismatched branch wins.
  always_comb begin : rr_select
    sel_vld = 1'b0;
    sel_idx = ptr_q;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      cand = sum[PW-1:0];
      if (!sel_vld && mis[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    en_d    = en_q;
    ack_d   = '0;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          idx_d   = sel_idx;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        en_d[idx_q] = bus.REQ[idx_q];
        ptr_d       = (idx_q == PW'(N - 1)) ? '0 : idx_q + PW'(1);
        // A request that reverted before APPLY costs no spacing slot.
        if (bus.REQ[idx_q] != en_q[idx_q]) begin
          ack_d[idx_q] = 1'b1;
          cnt_d        = CW'(STAGGER);
          state_d      = ST_WAIT;
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q <= ST_IDLE;
      en_q    <= '0;
      ack_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

`ifdef GF180MCU_OSU_SC_CLKSEQ_TESTMODE_EN
  // Test override is purely on the outputs; the sequencer keeps tracking REQ vs en_q.
  assign bus.EN  = en_q | {N{bus.TE}};
  assign bus.ACK = ack_q & ~{N{bus.TE}};
`else
  assign bus.EN  = en_q;
  assign bus.ACK = ack_q;
`endif
  assign bus.BUSY = busy_q;

endmodule
